// File: rtl/gpio_irq_ctrl.sv
// GPIO interrupt controller: per-pin synchronise, edge/level detect, pending latch,
// enable mask and a fixed-priority valid/ack presenter toward the CPU interrupt line.
//
// state   | meaning
// IDLE    | nothing presented, waiting for a masked request
// PRESENT | irq_id presented with irq_valid high, waiting for ack or withdrawal
// GAP     | one-cycle quiet slot after an ack before the next arbitration
module gpio_irq_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_WIDTH    = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wdata,
  output logic [DATA_WIDTH-1:0] cfg_rdata,
  output logic                  irq_valid,
  output logic [ID_WIDTH-1:0]   irq_id,
  input  logic                  irq_ack
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRESENT = 2'd1, GAP = 2'd2} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] s, s_d;
  logic [DATA_WIDTH-1:0] en_q, mode_q, pol_q, pend_q;
  logic [DATA_WIDTH-1:0] edge_act, lvl_act, active, w1c, ack_clr, pend_nxt;
  logic [DATA_WIDTH-1:0] req, id_mask;
  logic [ID_WIDTH-1:0]   winner;
  logic                  ack_hit, cur_req;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_d <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_d <= s;
    end
  end

  assign edge_act = (pol_q & s & ~s_d) | (~pol_q & ~s & s_d);
  assign lvl_act  = (pol_q & s) | (~pol_q & ~s);
  assign active   = (mode_q & edge_act) | (~mode_q & lvl_act);

  assign id_mask = DATA_WIDTH'(1) << irq_id;
  assign ack_hit = (state == PRESENT) && irq_ack;
  assign w1c     = (cfg_we && cfg_addr == 2'd3) ? cfg_wdata : '0;
  assign ack_clr = ack_hit ? id_mask : '0;

  // Edge pins hold until cleared, with a fresh detect beating any clear; level pins track.
  assign pend_nxt = (mode_q & (active | (pend_q & ~w1c & ~ack_clr))) | (~mode_q & active);

  assign req     = pend_q & en_q;
  assign cur_req = |(req & id_mask);

  always_comb begin
    winner = '0;
    for (int i = DATA_WIDTH-1; i >= 0; i--) begin
      if (req[i]) winner = ID_WIDTH'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q   <= '0;
      mode_q <= '0;
      pol_q  <= '0;
      pend_q <= '0;
    end else begin
      pend_q <= pend_nxt;
      if (cfg_we) begin
        case (cfg_addr)
          2'd0:    en_q   <= cfg_wdata;
          2'd1:    mode_q <= cfg_wdata;
          2'd2:    pol_q  <= cfg_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    case (cfg_addr)
      2'd0:    cfg_rdata = en_q;
      2'd1:    cfg_rdata = mode_q;
      2'd2:    cfg_rdata = pol_q;
      default: cfg_rdata = pend_q;
    endcase
  end

  // Ack is checked before withdrawal so a claim always completes through GAP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            irq_id    <= winner;
            irq_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (irq_ack) begin
            irq_valid <= 1'b0;
            state     <= GAP;
          end else if (!cur_req) begin
            irq_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        GAP:     state <= IDLE;
        default: begin
          irq_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gpio_irq_ctrl.md
Name: gpio_irq_ctrl

Overview:
- Interrupt controller for a bank of GPIO inputs.
- Per pin: synchronises the input, detects edges or levels with programmable polarity, latches pending state and applies an enable mask.
- A fixed-priority arbiter presents one interrupt at a time to the CPU-side interrupt line, using a valid/ack claim handshake.
- Sits between the GPIO pads (or bench stimulus drivers) and the platform interrupt input; configured through a small register port.

Parameters:
- DATA_WIDTH, 8, number of GPIO pins (1..32).
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (≥2).
- ID_WIDTH, 5, width of irq_id; must satisfy 2**ID_WIDTH ≥ DATA_WIDTH.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- gpio_in  in  DATA_WIDTH  raw asynchronous pin inputs.
- cfg_we  in  1  register write strobe.
- cfg_addr  in  2  register select: 0 ENABLE, 1 MODE (1=edge, 0=level), 2 POLARITY (1=rising/high, 0=falling/low), 3 PENDING.
- cfg_wdata  in  DATA_WIDTH  write data.
- cfg_rdata  out  DATA_WIDTH  combinational read of the register at cfg_addr.
- irq_valid  out  1  an interrupt is presented.
- irq_id  out  ID_WIDTH  index of the presented pin; stable while irq_valid is high.
- irq_ack  in  1  claim/complete strobe from the CPU side.

Behaviour:
- Reset (async assert, sync deassert):
  - ENABLE, MODE, POLARITY and PENDING = 0.
  - Synchroniser and edge-history flops = 0.
  - FSM = IDLE; irq_valid = 0; irq_id = 0.
- Synchroniser: SYNC_STAGES flops per pin. The edge detector compares the last sync stage with a one-flop history register s_d.
- Active condition per pin i:
  - Edge mode: (POL ? s & ~s_d : ~s & s_d).
  - Level mode: (POL ? s : ~s).
- PENDING[i] update, per cycle:
  - Edge mode: set on active; cleared by cfg write to addr 3 with wdata[i]=1 (W1C); cleared by ack of id i.
  - Simultaneous set and any clear: set wins.
  - Level mode: PENDING[i] = active each cycle. W1C and ack have no effect.
  - PENDING updates regardless of ENABLE. Enabling a pin with PENDING already set raises an interrupt.
- Masked request: req = PENDING & ENABLE.
- Priority: the lowest-index set bit of req wins.
- Latency: a pin change held at least one clk period becomes visible in PENDING SYNC_STAGES+1 rising edges after it is first sampled. irq_valid follows one cycle later: 4 cycles total at the default.
- FSM:
  - IDLE: if req≠0, latch irq_id = winner and go to PRESENT; irq_valid=1 from the next cycle.
  - PRESENT: irq_valid=1, irq_id held.
    - irq_ack=1: clear PENDING[irq_id] in edge mode and go to GAP.
    - Otherwise, if req[irq_id] drops (mask write, W1C, or level deasserted): withdraw, irq_valid=0, return to IDLE with no ack required.
    - Ack and withdrawal in the same cycle: ack takes precedence.
  - GAP: irq_valid=0 for exactly one cycle, then IDLE. A higher-priority pin becoming pending during PRESENT does not pre-empt; it is served after GAP.
- irq_ack outside PRESENT is ignored.
- Config writes to addr 0..2 take effect on the next cycle. Changing MODE or POLARITY may produce one spurious edge detect; software clears it with W1C.
- Write to addr 3 in level mode is ignored for those bits.
- A pin pulse shorter than one clk period may be lost; no capture guarantee.
- Reset asserted mid-handshake: irq_valid drops immediately (async); all state returns to reset values.

Test Plan:
- Rising-edge capture: DATA_WIDTH=8; ENABLE=0x01, MODE=0x01, POL=0x01. Pulse gpio_in[0] high for 500 cycles → PENDING=0x01 and irq_valid=1, irq_id=0 four cycles after the rise. Ack → PENDING=0x00, irq_valid low for ≥1 cycle, no second interrupt on the fall.
- Priority and no pre-emption: edge, rising, ENABLE=0xFF. Pin 5 rises; while presenting id 5, pin 2 rises → id stays 5 until ack. After the 1-cycle GAP, irq_valid=1 with id 2.
- Masking and late enable: ENABLE=0x00, edge on pin 3 → PENDING=0x08, irq_valid=0. Write ENABLE=0x08 → irq_valid=1, id 3 within 2 cycles.
- Level mode: MODE=0x00, POL=0x00 (active-low), ENABLE=0x02. gpio_in[1] low for 1000 cycles → irq_valid=1, id 1. Ack → GAP, then re-presents id 1 while the pin stays low. Pin returns high during PRESENT → withdrawal, irq_valid=0.
- Collisions: edge on pin 4 in the same cycle as a W1C of bit 4 → PENDING[4] stays 1. Edge on pin 4 in the same cycle as an ack of id 4 → PENDING[4] stays 1 and re-presents after GAP.
- Reset mid-operation: assert reset_n=0 while in PRESENT with PENDING=0x21 → irq_valid=0 asynchronously; all registers read 0 after release. 100-cycle gpio pulses after release behave as in the first scenario.
